// File: rtl/i2c_csr_mch.sv
`default_nettype none
// ============================================================================
// Module : i2c_csr_mch
// Multi-channel I2C CSR block on the USI slave bus with a one-shot command FIFO
// Rev    : 1.0  initial release
// ============================================================================
module i2c_csr_mch #(
  parameter int pBlockAdrsMap = 8,
  parameter int pAdrsMap      = 'h01,
  parameter int pBusAdrsBit   = 32,
  parameter int pI2CDivClk    = 16,
  parameter int pChNum        = 4,
  parameter int pRxW          = 16,
  parameter int pCmdDepth     = 8
) (
  input  logic                     iSysClk,
  input  logic                     iSysRst,
  input  logic [31:0]              iSUsiWd,
  input  logic [pBusAdrsBit-1:0]   iSUsiAdrs,
  input  logic                     iSUsiWCke,
  output logic [31:0]              oSUsiRd,
  output logic                     oSUsiVd,
  output logic                     oI2CEn,
  output logic [pI2CDivClk-1:0]    oI2CDiv,
  output logic [pChNum-1:0]        oChEn,
  output logic [31:0]              oCmdData,
  output logic                     oCmdVd,
  input  logic                     iCmdRd,
  input  logic [pChNum*pRxW-1:0]   iRxData,
  input  logic [pChNum-1:0]        iRxVd,
  input  logic [pChNum-1:0]        iNack,
  input  logic                     iBusy
);

  localparam int                       c_PTR_W   = $clog2(pCmdDepth);
  localparam int                       c_CNT_W   = c_PTR_W + 1;
  localparam logic [pBlockAdrsMap-1:0] c_BLK_SEL = pBlockAdrsMap'(pAdrsMap);
  localparam logic [c_CNT_W-1:0]       c_DEPTH   = c_CNT_W'(pCmdDepth);
  localparam logic [4:0]               c_CH_N    = 5'(pChNum);

  logic                  en_q,   en_d;
  logic [pI2CDivClk-1:0] div_q,  div_d;
  logic [pChNum-1:0]     chen_q, chen_d;
  logic [31:0]           mem_q  [pCmdDepth];
  logic [31:0]           mem_d  [pCmdDepth];
  logic [c_PTR_W-1:0]    wptr_q, wptr_d;
  logic [c_PTR_W-1:0]    rptr_q, rptr_d;
  logic [c_CNT_W-1:0]    cnt_q,  cnt_d;
  logic                  ovf_q,  ovf_d;
  logic [pChNum-1:0]     nack_q, nack_d;
  logic [pChNum-1:0]     new_q,  new_d;
  logic [pRxW-1:0]       rx_q   [pChNum];
  logic [pRxW-1:0]       rx_d   [pChNum];
  logic [31:0]           rd_q,   rd_d;
  logic                  vd_q,   vd_d;

  logic       w_hit, w_wr, w_rd;
  logic [7:0] w_off;
  logic [4:0] w_rx_idx;
  logic       w_rx_sel;
  logic       w_empty, w_full;
  logic       w_push_req, w_push_ok, w_pop, w_flush;
  logic [15:0] w_cnt16;

  assign w_hit    = (iSUsiAdrs[pBlockAdrsMap+7:8] == c_BLK_SEL);
  assign w_wr     = w_hit & iSUsiWCke;
  assign w_rd     = w_hit & ~iSUsiWCke;
  assign w_off    = iSUsiAdrs[7:0];
  // Channel capture window: 0x80 + 4*ch, word aligned, ch < pChNum
  assign w_rx_idx = w_off[6:2];
  assign w_rx_sel = w_off[7] & (w_off[1:0] == 2'b00) & (w_rx_idx < c_CH_N);

  assign w_empty    = (cnt_q == '0);
  assign w_full     = (cnt_q == c_DEPTH);
  assign w_cnt16    = 16'(cnt_q);
  assign w_push_req = w_wr & (w_off == 8'h0C);
  assign w_flush    = w_wr & (w_off == 8'h00) & iSUsiWd[1];
  assign w_pop      = iCmdRd & ~w_empty;
  assign w_push_ok  = w_push_req & (~w_full | w_pop);

  generate
    if (pBusAdrsBit > pBlockAdrsMap + 8) begin : g_unused_adrs
      logic w_unused_adrs;
      assign w_unused_adrs = ^iSUsiAdrs[pBusAdrsBit-1:pBlockAdrsMap+8];
    end
  endgenerate

  always_comb begin
    en_d   = en_q;
    div_d  = div_q;
    chen_d = chen_q;
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    nack_d = nack_q;
    new_d  = new_q;
    rx_d   = rx_q;
    rd_d   = rd_q;
    vd_d   = w_hit;

    if (w_wr) begin
      case (w_off)
        8'h00: en_d   = iSUsiWd[0];
        8'h04: div_d  = iSUsiWd[pI2CDivClk-1:0];
        8'h08: chen_d = iSUsiWd[pChNum-1:0];
        8'h14: begin
          nack_d = nack_q & ~iSUsiWd[pChNum-1:0];
          if (iSUsiWd[8]) ovf_d = 1'b0;
        end
        default: ;
      endcase
    end
    nack_d = nack_d | iNack;

    if (w_flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (w_push_ok) begin
        mem_d[wptr_q] = iSUsiWd;
        wptr_d        = wptr_q + c_PTR_W'(1);
      end
      if (w_pop) rptr_d = rptr_q + c_PTR_W'(1);
      if (w_push_ok && !w_pop)      cnt_d = cnt_q + c_CNT_W'(1);
      else if (!w_push_ok && w_pop) cnt_d = cnt_q - c_CNT_W'(1);
    end
    if (w_push_req && w_full && !w_pop) ovf_d = 1'b1;

    // A capture in the read cycle re-arms the flag the read would clear
    for (int ch = 0; ch < pChNum; ch++) begin
      if (w_rd && w_rx_sel && (w_rx_idx == 5'(ch))) new_d[ch] = 1'b0;
      if (iRxVd[ch]) begin
        rx_d[ch]  = iRxData[ch*pRxW +: pRxW];
        new_d[ch] = 1'b1;
      end
    end

    if (!w_hit) begin
      rd_d = iSUsiWd;
    end else begin
      rd_d = '0;
      if (w_rd) begin
        case (w_off)
          8'h00: rd_d[0] = en_q;
          8'h04: rd_d[pI2CDivClk-1:0] = div_q;
          8'h08: rd_d[pChNum-1:0] = chen_q;
          8'h10: rd_d = {w_cnt16, 13'b0, iBusy, w_full, w_empty};
          8'h14: begin
            rd_d[8]          = ovf_q;
            rd_d[pChNum-1:0] = nack_q;
          end
          8'h40: rd_d[pChNum-1:0] = new_q;
          default: begin
            for (int ch = 0; ch < pChNum; ch++) begin
              if (w_rx_sel && (w_rx_idx == 5'(ch))) rd_d[pRxW-1:0] = rx_q[ch];
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge iSysClk or posedge iSysRst) begin
    if (iSysRst) begin
      en_q   <= 1'b0;
      div_q  <= '1;
      chen_q <= '1;
      for (int i = 0; i < pCmdDepth; i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      nack_q <= '0;
      new_q  <= '0;
      for (int ch = 0; ch < pChNum; ch++) rx_q[ch] <= '0;
      rd_q   <= '0;
      vd_q   <= 1'b0;
    end else begin
      en_q   <= en_d;
      div_q  <= div_d;
      chen_q <= chen_d;
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      nack_q <= nack_d;
      new_q  <= new_d;
      rx_q   <= rx_d;
      rd_q   <= rd_d;
      vd_q   <= vd_d;
    end
  end

  assign oSUsiRd  = rd_q;
  assign oSUsiVd  = vd_q;
  assign oI2CEn   = en_q;
  assign oI2CDiv  = div_q;
  assign oChEn    = chen_q;
  assign oCmdVd   = ~w_empty;
  assign oCmdData = w_empty ? 32'h0 : mem_q[rptr_q];

endmodule
`default_nettype wire

// File: tb/tb_i2c_csr_mch.sv
`default_nettype none
// ============================================================================
// Module : tb_i2c_csr_mch
// Self-checking bench for i2c_csr_mch against a queue-based reference model
// Rev    : 1.0  initial release
// ============================================================================
module tb_i2c_csr_mch;

  localparam int CH    = 4;
  localparam int RXW   = 16;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] wd, adrs;
  logic        wcke;
  logic [31:0] s_rd;
  logic        s_vd, i2c_en;
  logic [15:0] i2c_div;
  logic [3:0]  ch_en;
  logic [31:0] cmd_data;
  logic        cmd_vd, cmd_rd;
  logic [63:0] rx_data;
  logic [3:0]  rx_vd, nack;
  logic        busy;

  always #5 clk = ~clk;

  i2c_csr_mch u_dut (
    .iSysClk  (clk),
    .iSysRst  (rst),
    .iSUsiWd  (wd),
    .iSUsiAdrs(adrs),
    .iSUsiWCke(wcke),
    .oSUsiRd  (s_rd),
    .oSUsiVd  (s_vd),
    .oI2CEn   (i2c_en),
    .oI2CDiv  (i2c_div),
    .oChEn    (ch_en),
    .oCmdData (cmd_data),
    .oCmdVd   (cmd_vd),
    .iCmdRd   (cmd_rd),
    .iRxData  (rx_data),
    .iRxVd    (rx_vd),
    .iNack    (nack),
    .iBusy    (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model state
  bit        m_en;
  bit [15:0] m_div;
  bit [3:0]  m_chen, m_nack, m_new;
  bit        m_ovf;
  bit [31:0] m_q[$];
  bit [15:0] m_rx[CH];
  bit [31:0] m_rd;
  bit        m_vd, m_rd_chk;

  task automatic model_reset();
    m_en = 0; m_div = 16'hFFFF; m_chen = 4'hF; m_nack = 0; m_new = 0; m_ovf = 0;
    m_q.delete();
    for (int c = 0; c < CH; c++) m_rx[c] = 0;
    m_rd = 0; m_vd = 0; m_rd_chk = 1;
  endtask

  // Advance the model by one clock using the inputs currently on the bus
  task automatic model_step();
    bit hit, wr, rd, pop, push, full0;
    bit [7:0] off;
    bit [31:0] r;
    int idx;
    hit = (adrs[15:8] == 8'h01);
    off = adrs[7:0];
    wr  = hit && wcke;
    rd  = hit && !wcke;
    r   = 0;
    idx = int'(off) - 128;
    if (!hit) r = wd;
    else if (rd) begin
      if (off == 8'h00) r[0] = m_en;
      else if (off == 8'h04) r[15:0] = m_div;
      else if (off == 8'h08) r[3:0] = m_chen;
      else if (off == 8'h10) begin
        r = 32'(m_q.size()) << 16;
        r[2] = busy;
        r[1] = (m_q.size() == DEPTH);
        r[0] = (m_q.size() == 0);
      end
      else if (off == 8'h14) begin r[8] = m_ovf; r[3:0] = m_nack; end
      else if (off == 8'h40) r[3:0] = m_new;
      else if (idx >= 0 && idx < 4*CH && idx % 4 == 0) r[15:0] = m_rx[idx/4];
    end
    m_rd_chk = !hit || rd;
    m_vd = hit;
    m_rd = r;

    if (wr && off == 8'h00) m_en = wd[0];
    if (wr && off == 8'h04) m_div = wd[15:0];
    if (wr && off == 8'h08) m_chen = wd[3:0];
    if (wr && off == 8'h14) begin
      m_nack &= ~wd[3:0];
      if (wd[8]) m_ovf = 0;
    end
    m_nack |= nack;

    pop   = cmd_rd && (m_q.size() > 0);
    push  = wr && (off == 8'h0C);
    full0 = (m_q.size() == DEPTH);
    if (wr && off == 8'h00 && wd[1]) m_q.delete();
    else begin
      if (pop) void'(m_q.pop_front());
      if (push) begin
        if (!full0 || pop) m_q.push_back(wd);
        else m_ovf = 1;
      end
    end

    for (int c = 0; c < CH; c++) begin
      if (rd && idx == 4*c) m_new[c] = 0;
      if (rx_vd[c]) begin
        m_rx[c]  = rx_data[c*RXW +: RXW];
        m_new[c] = 1;
      end
    end
  endtask

  task automatic check_outputs();
    chk("en", {31'b0, i2c_en}, {31'b0, m_en});
    chk("div", {16'b0, i2c_div}, {16'b0, m_div});
    chk("chen", {28'b0, ch_en}, {28'b0, m_chen});
    chk("cmd_vd", {31'b0, cmd_vd}, {31'b0, m_q.size() > 0});
    if (m_q.size() > 0) chk("cmd_data", cmd_data, m_q[0]);
    chk("usi_vd", {31'b0, s_vd}, {31'b0, m_vd});
    if (m_rd_chk) chk("usi_rd", s_rd, m_rd);
  endtask

  task automatic idle();
    adrs = 32'h0000_0200; wcke = 0; wd = $urandom;
    cmd_rd = 0; rx_vd = 0; nack = 0;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    idle();
  endtask

  task automatic bus_wr(input bit [7:0] a, input bit [31:0] d);
    adrs = {16'h0, 8'h01, a}; wd = d; wcke = 1;
    cycle();
  endtask

  task automatic bus_rd(input bit [7:0] a);
    adrs = {16'h0, 8'h01, a}; wd = $urandom; wcke = 0;
    cycle();
  endtask

  initial begin
    rst = 1; busy = 0; rx_data = 0;
    idle();
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_cmd_vd", {31'b0, cmd_vd}, 32'h0);
    chk("rst_cmd_data", cmd_data, 32'h0);
    chk("rst_div", {16'b0, i2c_div}, 32'hFFFF);
    chk("rst_chen", {28'b0, ch_en}, 32'hF);
    chk("rst_en", {31'b0, i2c_en}, 32'h0);
    chk("rst_usi_rd", s_rd, 32'h0);
    chk("rst_usi_vd", {31'b0, s_vd}, 32'h0);
    rst = 0;

    // Register write/read and daisy-chain passthrough
    bus_wr(8'h04, 32'h1234);
    bus_rd(8'h04);
    chk("div_read", s_rd, 32'h0000_1234);
    chk("div_read_vd", {31'b0, s_vd}, 32'h1);
    adrs = 32'h0000_0300; wd = 32'hCAFE_F00D; wcke = 0;
    cycle();
    chk("miss_vd", {31'b0, s_vd}, 32'h0);
    chk("miss_rd", s_rd, 32'hCAFE_F00D);

    // Overflow on the ninth push, then drain in order
    for (int i = 0; i < 9; i++) bus_wr(8'h0C, 32'hA0 + i);
    bus_rd(8'h10);
    chk("status_full", s_rd, 32'h0008_0002);
    bus_rd(8'h14);
    chk("ovf_set", s_rd, 32'h0000_0100);
    for (int i = 0; i < 8; i++) begin
      chk("pop_order", cmd_data, 32'hA0 + i);
      cmd_rd = 1;
      cycle();
    end
    bus_rd(8'h10);
    chk("status_empty", s_rd, 32'h0000_0001);
    bus_wr(8'h14, 32'h100);
    bus_rd(8'h14);
    chk("ovf_clr", s_rd, 32'h0);

    // Push and pop together while full
    for (int i = 0; i < 8; i++) bus_wr(8'h0C, 32'hC0 + i);
    adrs = {16'h0, 8'h01, 8'h0C}; wd = 32'hB0; wcke = 1; cmd_rd = 1;
    cycle();
    bus_rd(8'h10);
    chk("status_pushpop", s_rd, 32'h0008_0002);
    bus_rd(8'h14);
    chk("no_ovf", s_rd, 32'h0);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) chk("last_b0", cmd_data, 32'hB0);
      cmd_rd = 1;
      cycle();
    end

    // Channel capture and read-to-clear
    rx_vd = 4'b0100; rx_data = 64'h0000_BEEF_0000_0000;
    cycle();
    bus_rd(8'h40);
    chk("new_set", s_rd, 32'h4);
    bus_rd(8'h88);
    chk("rx2", s_rd, 32'h0000_BEEF);
    bus_rd(8'h40);
    chk("new_clr", s_rd, 32'h0);
    rx_vd = 4'b0100; rx_data = 64'h0000_1357_0000_0000;
    cycle();
    adrs = {16'h0, 8'h01, 8'h88}; wcke = 0; rx_vd = 4'b0100; rx_data = 64'h0000_2468_0000_0000;
    cycle();
    chk("rx2_preclear", s_rd, 32'h0000_1357);
    bus_rd(8'h40);
    chk("new_kept", s_rd, 32'h4);
    bus_rd(8'h88);
    chk("rx2_new", s_rd, 32'h0000_2468);

    // NACK set beats W1C in the same cycle
    adrs = {16'h0, 8'h01, 8'h14}; wd = 32'h8; wcke = 1; nack = 4'b1000;
    cycle();
    bus_rd(8'h14);
    chk("nack_set_wins", s_rd, 32'h8);
    bus_wr(8'h14, 32'h8);
    bus_rd(8'h14);
    chk("nack_clr", s_rd, 32'h0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int sel;
      bit [7:0] offs [11];
      offs = '{8'h00, 8'h04, 8'h08, 8'h10, 8'h14, 8'h40, 8'h80, 8'h84, 8'h88, 8'h8C, 8'h20};
      sel = $urandom_range(0, 99);
      busy    = $urandom;
      cmd_rd  = ($urandom_range(0, 2) == 0);
      rx_vd   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      rx_data = {$urandom, $urandom};
      nack    = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0;
      wd      = $urandom;
      if (sel < 40) begin
        adrs = {16'h0, 8'h01, offs[$urandom_range(0, 10)]}; wcke = 0;
      end else if (sel < 70) begin
        adrs = {16'h0, 8'h01, 8'h0C}; wcke = 1;
      end else if (sel < 75) begin
        adrs = {16'h0, 8'h01, 8'h00}; wcke = 1;
        if ($urandom_range(0, 3) != 0) wd[1] = 0;
      end else if (sel < 85) begin
        adrs = {16'h0, 8'h01, offs[$urandom_range(1, 4)]}; wcke = 1;
      end else begin
        adrs = {$urandom} & 32'hFFFF_FEFF; wcke = $urandom;
        if (adrs[15:8] == 8'h01) adrs[15:8] = 8'h05;
      end
      cycle();
    end
    busy = 0;

    // Asynchronous reset with work in flight
    bus_wr(8'h00, 32'h2);
    for (int i = 0; i < 3; i++) bus_wr(8'h0C, 32'h50 + i);
    rx_vd = 4'b0010; rx_data = 64'h0000_0000_1111_0000;
    cycle();
    #2 rst = 1;
    #1;
    chk("arst_cmd_vd", {31'b0, cmd_vd}, 32'h0);
    chk("arst_div", {16'b0, i2c_div}, 32'hFFFF);
    chk("arst_chen", {28'b0, ch_en}, 32'hF);
    model_reset();
    @(negedge clk);
    rst = 0;
    bus_rd(8'h10);
    chk("arst_status", s_rd, 32'h0000_0001);
    bus_rd(8'h40);
    chk("arst_new", s_rd, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
